// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the shift-add multiplier controller.
// The optional early-exit behaviour is enabled with MULTIPLIER_EARLY_EXIT_EN.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; a single bit still suffices for N = 2.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multiplier_counter.sv
// Iteration down-counter: preset to N-1 on accept, decremented once per STEP cycle.
module multiplier_counter
    import multiplier_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic do_preset,
    input  logic do_decrement,
    output logic is_zero
);

    localparam int CW = cnt_width(N);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: preset has priority, otherwise decrement or hold.
    always_comb begin
        count_d = count_q;
        if (do_preset) begin
            count_d = CW'(N - 1);
        end else if (do_decrement) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign is_zero = (count_q == {CW{1'b0}});

endmodule

// File: rtl/multiplier_controller.sv
// Sequencing FSM for the iterative shift-add multiplier datapath.
// Define MULTIPLIER_EARLY_EXIT_EN to leave STEP as soon as the multiplier reaches zero.
module multiplier_controller
    import multiplier_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    input  logic flush,
    output logic busy,
    output logic dp_load,
    output logic dp_add,
    output logic dp_shift,
    input  logic mplier_lsb,
    input  logic mplier_is_zero
);

    state_t state_q;
    state_t state_d;
    logic   cnt_zero_s;
    logic   do_preset_s;
    logic   do_decrement_s;
    logic   early_zero_s;

`ifdef MULTIPLIER_EARLY_EXIT_EN
    assign early_zero_s = mplier_is_zero;
`else
    logic unused_mplier_is_zero_s;
    assign unused_mplier_is_zero_s = mplier_is_zero;
    assign early_zero_s            = 1'b0;
`endif

    multiplier_counter #(
        .N (N)
    ) u_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .do_preset    (do_preset_s),
        .do_decrement (do_decrement_s),
        .is_zero      (cnt_zero_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) state_d = STEP;
                    else          state_d = IDLE;
                end
                STEP: begin
                    if (early_zero_s || cnt_zero_s) state_d = DONE;
                    else                            state_d = STEP;
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                    else           state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Mealy outputs and counter controls; the flush cycle issues nothing.
    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        busy           = 1'b0;
        dp_load        = 1'b0;
        dp_add         = 1'b0;
        dp_shift       = 1'b0;
        do_preset_s    = 1'b0;
        do_decrement_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready    = ~flush;
                dp_load     = in_valid & ~flush;
                do_preset_s = in_valid & ~flush;
            end
            STEP: begin
                busy = 1'b1;
                if (!flush && !early_zero_s) begin
                    dp_shift       = 1'b1;
                    dp_add         = mplier_lsb;
                    do_decrement_s = ~cnt_zero_s;
                end else begin
                    dp_shift       = 1'b0;
                    dp_add         = 1'b0;
                    do_decrement_s = 1'b0;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = ~flush;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier_controller.sv
// Directed bench for multiplier_controller: N=4 sequencing cases plus an N=8 product sweep.
`timescale 1ns/1ps
module tb_multiplier_controller;

    logic clock = 1'b0;
    logic reset_n;

    logic in_valid4, in_ready4, out_valid4, out_ready4, flush4, busy4;
    logic dp_load4, dp_add4, dp_shift4;
    logic [3:0] op_a4, op_b4, mp4_r;
    logic [7:0] mc4_r, acc4_r;

    logic in_valid8, in_ready8, out_valid8, out_ready8, flush8, busy8;
    logic dp_load8, dp_add8, dp_shift8;
    logic [7:0]  op_a8, op_b8, mp8_r;
    logic [15:0] mc8_r, acc8_r;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    multiplier_controller #(.N(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .flush(flush4), .busy(busy4),
        .dp_load(dp_load4), .dp_add(dp_add4), .dp_shift(dp_shift4),
        .mplier_lsb(mp4_r[0]), .mplier_is_zero(mp4_r == 4'd0)
    );

    multiplier_controller #(.N(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .flush(flush8), .busy(busy8),
        .dp_load(dp_load8), .dp_add(dp_add8), .dp_shift(dp_shift8),
        .mplier_lsb(mp8_r[0]), .mplier_is_zero(mp8_r == 8'd0)
    );

    // Datapath model for N=4: fixed accumulator, left-shifting multiplicand.
    always @(posedge clock) begin
        if (dp_load4) begin
            mc4_r  <= {4'd0, op_a4};
            mp4_r  <= op_b4;
            acc4_r <= 8'd0;
        end else begin
            if (dp_add4) acc4_r <= acc4_r + mc4_r;
            if (dp_shift4) begin
                mc4_r <= mc4_r << 1;
                mp4_r <= mp4_r >> 1;
            end
        end
    end

    // Datapath model for N=8.
    always @(posedge clock) begin
        if (dp_load8) begin
            mc8_r  <= {8'd0, op_a8};
            mp8_r  <= op_b8;
            acc8_r <= 16'd0;
        end else begin
            if (dp_add8) acc8_r <= acc8_r + mc8_r;
            if (dp_shift8) begin
                mc8_r <= mc8_r << 1;
                mp8_r <= mp8_r >> 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one N=4 operation from IDLE; called just after a rising edge.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b,
                           input int stall, input int flush_at);
        int   steps;
        int   hb;
        bit   idle_last;
        bit   exp_idle;
        logic [7:0] prod;
        hb = 0;
        for (int i = 0; i < 4; i++) if (b[i]) hb = i + 1;
        steps     = 4;
        idle_last = 1'b0;
`ifdef MULTIPLIER_EARLY_EXIT_EN
        if (hb < 4) begin
            steps     = hb + 1;
            idle_last = 1'b1;
        end
`endif
        prod = {4'd0, a} * {4'd0, b};
        in_valid4 = 1'b1; op_a4 = a; op_b4 = b;
        out_ready4 = (stall == 0); flush4 = 1'b0;
        @(negedge clock);
        check_eq("accept_ready", in_ready4, 1'b1);
        check_eq("accept_load", dp_load4, 1'b1);
        @(posedge clock); #1;
        in_valid4 = 1'b0; op_a4 = 4'd0; op_b4 = 4'd0;
        for (int c = 1; c <= steps; c++) begin
            flush4 = (c == flush_at);
            @(negedge clock);
            if (c == flush_at) begin
                check_eq("flush_shift", dp_shift4, 1'b0);
                check_eq("flush_add", dp_add4, 1'b0);
                check_eq("flush_busy", busy4, 1'b1);
                @(posedge clock); #1;
                flush4 = 1'b0;
                @(negedge clock);
                check_eq("flush_idle_busy", busy4, 1'b0);
                check_eq("flush_idle_ready", in_ready4, 1'b1);
                check_eq("flush_no_valid", out_valid4, 1'b0);
                @(posedge clock); #1;
                @(negedge clock);
                check_eq("flush_no_valid_late", out_valid4, 1'b0);
                @(posedge clock); #1;
                return;
            end
            exp_idle = idle_last && (c == steps);
            check_eq("step_shift", dp_shift4, exp_idle ? 1'b0 : 1'b1);
            check_eq("step_add", dp_add4, exp_idle ? 1'b0 : b[c-1]);
            check_eq("step_ready", in_ready4, 1'b0);
            check_eq("step_valid", out_valid4, 1'b0);
            check_eq("step_busy", busy4, 1'b1);
            @(posedge clock); #1;
        end
        for (int d = 0; d <= stall; d++) begin
            out_ready4 = (d == stall);
            @(negedge clock);
            check_eq("done_valid", out_valid4, 1'b1);
            check_eq("done_ready", in_ready4, 1'b0);
            check_eq("done_strobes", {dp_load4, dp_add4, dp_shift4}, 3'b000);
            check_eq("done_product", acc4_r, prod);
            @(posedge clock); #1;
        end
        out_ready4 = 1'b1;
        @(negedge clock);
        check_eq("after_busy", busy4, 1'b0);
        check_eq("after_ready", in_ready4, 1'b1);
        check_eq("after_valid", out_valid4, 1'b0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a8, b8;
        logic [15:0] p8;
        int step_cnt, shift_cnt;
        reset_n = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; flush4 = 1'b0; op_a4 = 4'd0; op_b4 = 4'd0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; flush8 = 1'b0; op_a8 = 8'd0; op_b8 = 8'd0;
        mp4_r = 4'd0; mc4_r = 8'd0; acc4_r = 8'd0;
        mp8_r = 8'd0; mc8_r = 16'd0; acc8_r = 16'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("reset_ready", in_ready4, 1'b1);
        check_eq("reset_busy", busy4, 1'b0);
        check_eq("reset_valid", out_valid4, 1'b0);
        check_eq("reset_strobes", {dp_load4, dp_add4, dp_shift4}, 3'b000);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Basic op and backpressure.
        run_op4(4'd13, 4'b1011, 0, -1);
        run_op4(4'd13, 4'b1011, 3, -1);
        run_op4(4'd15, 4'b1111, 0, -1);
        // Early-exit boundary multipliers.
        run_op4(4'd7, 4'b0001, 0, -1);
        run_op4(4'd9, 4'b0000, 0, -1);
        // Abort in the second STEP cycle.
        run_op4(4'd9, 4'b1011, 0, 2);

        // flush wins over in_valid in IDLE.
        in_valid4 = 1'b1; flush4 = 1'b1; op_a4 = 4'd3; op_b4 = 4'd3;
        @(negedge clock);
        check_eq("idle_flush_ready", in_ready4, 1'b0);
        check_eq("idle_flush_load", dp_load4, 1'b0);
        @(posedge clock); #1;
        in_valid4 = 1'b0; flush4 = 1'b0;
        @(negedge clock);
        check_eq("idle_flush_busy", busy4, 1'b0);
        @(posedge clock); #1;

        // Asynchronous reset in the third STEP cycle.
        in_valid4 = 1'b1; op_a4 = 4'd6; op_b4 = 4'b1011;
        @(posedge clock); #1;
        in_valid4 = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_eq("prereset_shift", dp_shift4, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_busy", busy4, 1'b0);
        check_eq("rst_strobes", {dp_load4, dp_add4, dp_shift4}, 3'b000);
        check_eq("rst_valid", out_valid4, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_op4(4'd5, 4'b0001, 0, -1);

        // N=8 sweep; multiplier MSB forced so every build runs all 8 STEP cycles.
        for (int t = 0; t < 6; t++) begin
            a8 = (t == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            b8 = (t == 0) ? 8'hFF : 8'($urandom_range(128, 255));
            p8 = {8'd0, a8} * {8'd0, b8};
            in_valid8 = 1'b1; op_a8 = a8; op_b8 = b8;
            @(negedge clock);
            check_eq("n8_ready", in_ready8, 1'b1);
            check_eq("n8_load", dp_load8, 1'b1);
            @(posedge clock); #1;
            in_valid8 = 1'b0;
            step_cnt = 0; shift_cnt = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clock);
                if (out_valid8) break;
                if (busy8) step_cnt++;
                if (dp_shift8) shift_cnt++;
                @(posedge clock); #1;
            end
            check_eq("n8_valid", out_valid8, 1'b1);
            check_eq("n8_step_len", step_cnt, 8);
            check_eq("n8_shifts", shift_cnt, 8);
            check_eq("n8_product", acc8_r, p8);
            @(posedge clock); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
